// File: rtl/n64a_vdemux_gen_pkg.sv
// Shared constants and types for the N64 VD bus demultiplexer and its lock tracker.
package n64a_vdemux_gen_pkg;

    localparam int unsigned PRM_N16BIT     = 0;
    localparam int unsigned PRM_NDO_DEBLUR = 1;
    localparam int unsigned PRM_PALMODE    = 2;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    // Bits needed to hold values 0..maxval (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/n64a_vdemux_lock.sv
// Lock state machine, good-packet counter and saturating malformed-packet counter.
module n64a_vdemux_lock
    import n64a_vdemux_gen_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 VCLK,
    input  logic                 nRST,
    input  logic                 sync_cyc,
    input  logic                 pkt_good,
    input  logic                 err_clr,
    output logic                 pkt_close_c,
    output logic                 lock_o,
    output logic                 pkt_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int unsigned GOOD_W = cnt_width(LOCK_COUNT);

    lock_state_e       state, state_nxt;
    logic [GOOD_W-1:0] good_cnt, good_cnt_nxt;
    logic              pkt_bad;

    // The first sync after reset only opens a packet; nothing closes until then.
    assign pkt_close_c = sync_cyc && (state != ST_UNLOCKED);
    assign pkt_bad     = pkt_close_c && !pkt_good;

    always_ff @(posedge VCLK or negedge nRST) begin : state_reg
        if (!nRST) begin
            state    <= ST_UNLOCKED;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        case (state)
            ST_UNLOCKED: begin
                if (sync_cyc) begin
                    state_nxt    = ST_ACQUIRE;
                    good_cnt_nxt = '0;
                end
            end
            ST_ACQUIRE: begin
                if (pkt_close_c) begin
                    if (!pkt_good) begin
                        good_cnt_nxt = '0;
                    end else if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
                        state_nxt    = ST_LOCKED;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + GOOD_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (pkt_bad) begin
                    state_nxt    = ST_ACQUIRE;
                    good_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_UNLOCKED;
                good_cnt_nxt = '0;
            end
        endcase
    end

    // Registered status; clear wins over a coincident increment.
    always_ff @(posedge VCLK or negedge nRST) begin : status_reg
        if (!nRST) begin
            lock_o    <= 1'b0;
            pkt_err_o <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            lock_o    <= (state_nxt == ST_LOCKED);
            pkt_err_o <= pkt_bad;
            if (err_clr) begin
                err_cnt_o <= '0;
            end else if (pkt_bad && !(&err_cnt_o)) begin
                err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/n64a_vdemux_gen.sv
// N64 VD bus demultiplexer: assembles sync + NUM_CH colour phases into one word,
// with 16-bit-mode truncation, deblur blanking and packet-integrity tracking.
module n64a_vdemux_gen
    import n64a_vdemux_gen_pkg::*;
#(
    parameter int unsigned          COLOR_WIDTH = 7,
    parameter int unsigned          SYNC_WIDTH  = 4,
    parameter int unsigned          NUM_CH      = 3,
    parameter logic [4*NUM_CH-1:0]  TRUNC_VEC   = 12'h212,
    parameter int unsigned          LOCK_COUNT  = 8,
    parameter int unsigned          ERR_CNT_W   = 8
) (
    input  logic                          VCLK,
    input  logic                          nRST,
    input  logic                          nVDSYNC,
    input  logic [COLOR_WIDTH-1:0]        VD_i,
    input  logic [2:0]                    demuxparams_i,
    input  logic                          err_clr_i,
    output logic                          vdata_valid_o,
    output logic [SYNC_WIDTH-1:0]         vdata_sy_o,
    output logic [NUM_CH*COLOR_WIDTH-1:0] vdata_co_o,
    output logic                          lock_o,
    output logic                          pkt_err_o,
    output logic [ERR_CNT_W-1:0]          err_cnt_o
);

    localparam int unsigned CO_W = NUM_CH * COLOR_WIDTH;
    localparam int unsigned PH_W = cnt_width(NUM_CH + 1);
    localparam logic [PH_W-1:0] PH_SAT = PH_W'(NUM_CH + 1);

    logic                   sync_cyc;
    logic                   pkt_close;
    logic                   pkt_good;
    logic [PH_W-1:0]        phase_cnt;
    logic                   ovf;
    logic [SYNC_WIDTH-1:0]  sy_buf;
    logic [COLOR_WIDTH-1:0] ch_buf    [NUM_CH];
    logic [COLOR_WIDTH-1:0] keep_mask [NUM_CH];
    logic [CO_W-1:0]        co_flat;
    logic                   nblank;

    assign sync_cyc = !nVDSYNC;
    assign pkt_good = (phase_cnt == PH_SAT) && !ovf;

    // Phase counter saturates at NUM_CH+1; ovf marks any colour cycle beyond that.
    always_ff @(posedge VCLK or negedge nRST) begin : phase_reg
        if (!nRST) begin
            phase_cnt <= '0;
            ovf       <= 1'b0;
        end else if (sync_cyc) begin
            phase_cnt <= PH_W'(1);
            ovf       <= 1'b0;
        end else if (phase_cnt == PH_SAT) begin
            ovf       <= 1'b1;
        end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
        end
    end

    always_comb begin : trunc_masks
        for (int k = 0; k < NUM_CH; k++) begin
            keep_mask[k] = demuxparams_i[PRM_N16BIT] ? {COLOR_WIDTH{1'b1}}
                         : ({COLOR_WIDTH{1'b1}} << TRUNC_VEC[4*k +: 4]);
        end
    end

    always_ff @(posedge VCLK or negedge nRST) begin : capture
        if (!nRST) begin
            sy_buf <= '0;
            for (int k = 0; k < NUM_CH; k++) ch_buf[k] <= '0;
        end else if (sync_cyc) begin
            sy_buf <= VD_i[SYNC_WIDTH-1:0];
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (phase_cnt == PH_W'(k + 1)) ch_buf[k] <= VD_i & keep_mask[k];
            end
        end
    end

    // Channel 0 lands in the MSBs.
    always_comb begin : pack
        co_flat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            co_flat[(NUM_CH-1-k)*COLOR_WIDTH +: COLOR_WIDTH] = ch_buf[k];
        end
    end

    // The nblank chosen at a sync governs the packet that sync opens.
    always_ff @(posedge VCLK or negedge nRST) begin : out_reg
        if (!nRST) begin
            nblank        <= 1'b1;
            vdata_valid_o <= 1'b0;
            vdata_sy_o    <= '0;
            vdata_co_o    <= '0;
        end else begin
            vdata_valid_o <= pkt_close;
            if (pkt_close) begin
                vdata_sy_o <= sy_buf;
                if (pkt_good && nblank) vdata_co_o <= co_flat;
            end
            if (sync_cyc) begin
                if (demuxparams_i[PRM_NDO_DEBLUR]) begin
                    nblank <= 1'b1;
                end else if (!sy_buf[0] && VD_i[0]) begin
                    nblank <= demuxparams_i[PRM_PALMODE];
                end else begin
                    nblank <= ~nblank;
                end
            end
        end
    end

    n64a_vdemux_lock #(
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_CNT_W  (ERR_CNT_W)
    ) u_lock (
        .VCLK        (VCLK),
        .nRST        (nRST),
        .sync_cyc    (sync_cyc),
        .pkt_good    (pkt_good),
        .err_clr     (err_clr_i),
        .pkt_close_c (pkt_close),
        .lock_o      (lock_o),
        .pkt_err_o   (pkt_err_o),
        .err_cnt_o   (err_cnt_o)
    );

endmodule
